// File: rtl/he_pkg.sv
// he_pkg: shared types and constants for the histogram-equalization LUT
// remap block (state encoding, table geometry, default image size).
package he_pkg;

    // Remap controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } remap_state_t;

    // Transform table geometry
    localparam int LUT_DEPTH = 256;
    localparam int LUT_AW    = 8;
    localparam int PIX_W     = 8;

    // Default frame dimensions
    localparam int DEF_IMAGE_WIDTH  = 660;
    localparam int DEF_IMAGE_HEIGHT = 440;

    // Last table address; the load ends after this entry is written
    localparam logic [LUT_AW-1:0] LUT_LAST_ADDR = 8'd255;

    // Next load address; wraps naturally at the table size
    function automatic logic [LUT_AW-1:0] lut_next_addr(input logic [LUT_AW-1:0] addr);
        return addr + 8'd1;
    endfunction

endpackage

// File: rtl/he_lut_ram.sv
// he_lut_ram: 256x8 transform table storage. One synchronous write port
// used while the table streams in, one combinational read port used by the
// remap path. Contents are deliberately not reset: a table is only trusted
// after a complete load.
module he_lut_ram
    import he_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [LUT_AW-1:0] waddr,
    input  logic [PIX_W-1:0]  wdata,
    input  logic [LUT_AW-1:0] raddr,
    output logic [PIX_W-1:0]  rdata
);

    logic [PIX_W-1:0] mem_r [LUT_DEPTH];

    // Table write port, one entry per cycle during load
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/he_lut_remap.sv
// he_lut_remap: captures the 256-entry equalization table that HE streams
// out after 'done', then remaps each incoming pixel through it onto a
// registered valid/ready output stream with backpressure.
// Optional feature: define HE_REMAP_EOL_EN to add the out_eol port and the
// column counter that drives it.
module he_lut_remap
    import he_pkg::*;
#(
    parameter int IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
    parameter int NUM_PIXELS   = IMAGE_WIDTH * IMAGE_HEIGHT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             done,
    input  logic [PIX_W-1:0] tbl_data,
    input  logic             in_valid,
    input  logic [PIX_W-1:0] in_pixel,
    output logic             in_ready,
    output logic             out_valid,
    output logic [PIX_W-1:0] out_pixel,
    output logic             out_last,
    input  logic             out_ready,
`ifdef HE_REMAP_EOL_EN
    output logic             out_eol,
`endif
    output logic             table_ready
);

    // Legacy-compatible state constants mapped onto the package enum
    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_LOAD = LOAD;
    localparam logic [1:0] ST_RUN  = RUN;

    localparam int CNT_W = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
    localparam logic [CNT_W-1:0] PIX_LAST = CNT_W'(NUM_PIXELS - 1);

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic              load_start_s;
    logic              load_we_s;
    logic [LUT_AW-1:0] load_addr_r;
    logic [PIX_W-1:0]  lut_rd_s;
    logic              in_ready_s;
    logic              accept_s;
    logic [CNT_W-1:0]  frame_cnt_r;
    logic              frame_end_s;
    logic              out_valid_r;
    logic [PIX_W-1:0]  out_pixel_r;
    logic              out_last_r;
    logic              table_ready_r;
    logic              eol_s;

    // Next-state decode for the load/run controller
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (done) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                // done is ignored here; the load always runs to the last entry
                if (load_addr_r == LUT_LAST_ADDR) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_RUN: begin
                if (done) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    assign load_start_s = (state_r != ST_LOAD) && (state_nxt_s == ST_LOAD);
    assign load_we_s    = (state_r == ST_LOAD);

    // Only accept a pixel when the output register is free or draining now
    assign in_ready_s  = (state_r == ST_RUN) && (!out_valid_r || out_ready);
    assign accept_s    = in_valid && in_ready_s;
    assign frame_end_s = (frame_cnt_r == PIX_LAST);

    // Controller state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Table load address: cleared on LOAD entry, advances every LOAD cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_addr_r <= 8'd0;
        end else if (load_start_s) begin
            load_addr_r <= 8'd0;
        end else if (load_we_s) begin
            load_addr_r <= lut_next_addr(load_addr_r);
        end else begin
            load_addr_r <= load_addr_r;
        end
    end

    he_lut_ram u_lut (
        .clk   (clk),
        .we    (load_we_s),
        .waddr (load_addr_r),
        .wdata (tbl_data),
        .raddr (in_pixel),
        .rdata (lut_rd_s)
    );

    // Table-ready flag: high exactly while the controller is in RUN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            table_ready_r <= 1'b0;
        end else begin
            table_ready_r <= (state_nxt_s == ST_RUN);
        end
    end

    // Frame pixel counter; restarts on every table (re)load
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt_r <= '0;
        end else if (load_start_s) begin
            frame_cnt_r <= '0;
        end else if (accept_s) begin
            if (frame_end_s) begin
                frame_cnt_r <= '0;
            end else begin
                frame_cnt_r <= frame_cnt_r + CNT_W'(1);
            end
        end else begin
            frame_cnt_r <= frame_cnt_r;
        end
    end

`ifdef HE_REMAP_EOL_EN
    localparam int COL_W = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMAGE_WIDTH - 1);

    logic [COL_W-1:0] col_cnt_r;
    logic             out_eol_r;

    assign eol_s = (col_cnt_r == COL_LAST);

    // Column counter for end-of-line marking; restarts on every table load
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_cnt_r <= '0;
        end else if (load_start_s) begin
            col_cnt_r <= '0;
        end else if (accept_s) begin
            if (eol_s) begin
                col_cnt_r <= '0;
            end else begin
                col_cnt_r <= col_cnt_r + COL_W'(1);
            end
        end else begin
            col_cnt_r <= col_cnt_r;
        end
    end

    // End-of-line flag travels with the output word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_eol_r <= 1'b0;
        end else if (accept_s) begin
            out_eol_r <= eol_s;
        end else if (out_ready) begin
            out_eol_r <= 1'b0;
        end else begin
            out_eol_r <= out_eol_r;
        end
    end

    assign out_eol = out_eol_r;
`else
    assign eol_s = 1'b0;
`endif

    // Output register: load on accept, clear when drained, hold under backpressure
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            out_pixel_r <= 8'd0;
            out_last_r  <= 1'b0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            out_pixel_r <= lut_rd_s;
            out_last_r  <= frame_end_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
            out_pixel_r <= out_pixel_r;
            out_last_r  <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
            out_pixel_r <= out_pixel_r;
            out_last_r  <= out_last_r;
        end
    end

    assign in_ready    = in_ready_s;
    assign out_valid   = out_valid_r;
    assign out_pixel   = out_pixel_r;
    assign out_last    = out_last_r;
    assign table_ready = table_ready_r;

endmodule

// File: tb/tb_he_lut_remap.sv
// tb_he_lut_remap: scoreboard bench for he_lut_remap on a 4x2 frame.
// Expected words are pushed when a pixel handshakes and popped when the
// DUT presents an output that the sink accepts.
module tb_he_lut_remap;

    logic       clk;
    logic       reset;
    logic       done;
    logic [7:0] tbl_data;
    logic       in_valid;
    logic [7:0] in_pixel;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_pixel;
    logic       out_last;
    logic       out_ready;
    logic       table_ready;
`ifdef HE_REMAP_EOL_EN
    logic       out_eol;
`endif

    he_lut_remap #(
        .IMAGE_WIDTH  (4),
        .IMAGE_HEIGHT (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .done        (done),
        .tbl_data    (tbl_data),
        .in_valid    (in_valid),
        .in_pixel    (in_pixel),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_pixel   (out_pixel),
        .out_last    (out_last),
        .out_ready   (out_ready),
`ifdef HE_REMAP_EOL_EN
        .out_eol     (out_eol),
`endif
        .table_ready (table_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    logic [9:0] exp_q[$];
    logic [7:0] model_lut [256];
    int         m_cnt = 0;
    int         m_col = 0;
    logic       stall_r = 1'b0;
    logic [7:0] held_pix;
    logic       held_last;
    logic [9:0] e;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one pixel and hold it until accepted (bounded)
    task automatic send(input logic [7:0] p);
        int   n;
        logic acc;
        n = 0;
        acc = 1'b0;
        in_valid = 1'b1;
        in_pixel = p;
        while (!acc && n < 50) begin
            #1;
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
    endtask

    // Let all pending outputs drain (bounded)
    task automatic drain();
        int n;
        n = 0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        chk("drain", exp_q.size(), 32'd0);
        tick();
    endtask

    // Drive done then 256 table entries; mode 0 inverse, 1 identity.
    // done_at: entry index at which done is pulsed again (-1 none).
    // abort_at: entry index at which reset is asserted (-1 none).
    task automatic load_table(input int mode, input int done_at, input int abort_at);
        done = 1'b1;
        tick();
        done = 1'b0;
        in_valid = 1'b0;
        m_cnt = 0;
        m_col = 0;
        for (int k = 0; k < 256; k++) begin
            tbl_data = (mode == 1) ? 8'(k) : 8'(255 - k);
            done = (k == done_at);
            if (k == abort_at) begin
                reset = 1'b1;
                #1;
                chk("rst_in_ready", in_ready, 32'd0);
                chk("rst_out_valid", out_valid, 32'd0);
                chk("rst_out_pixel", out_pixel, 32'd0);
                chk("rst_out_last", out_last, 32'd0);
                chk("rst_table_ready", table_ready, 32'd0);
                exp_q.delete();
                m_cnt = 0;
                m_col = 0;
                tick();
                reset = 1'b0;
                done = 1'b0;
                return;
            end
            #1;
            chk("load_in_ready", in_ready, 32'd0);
            if (k == 0 || k == 255) chk("load_table_ready", table_ready, 32'd0);
            tick();
        end
        done = 1'b0;
        chk("table_ready_rise", table_ready, 32'd1);
        for (int k = 0; k < 256; k++) begin
            model_lut[k] = (mode == 1) ? 8'(k) : 8'(255 - k);
        end
    endtask

    // Output scoreboard and backpressure hold monitor
    always @(negedge clk) begin
        if (!reset) begin
            if (stall_r) begin
                chk("hold_valid", out_valid, 32'd1);
                chk("hold_pixel", out_pixel, held_pix);
                chk("hold_last", out_last, held_last);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_output", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("pixel", out_pixel, e[7:0]);
                    chk("last", out_last, e[8]);
`ifdef HE_REMAP_EOL_EN
                    chk("eol", out_eol, e[9]);
`endif
                end
            end
            stall_r   = out_valid && !out_ready;
            held_pix  = out_pixel;
            held_last = out_last;
            if (in_valid && in_ready) begin
                exp_q.push_back({(m_col == 3), (m_cnt == 7), model_lut[in_pixel]});
                m_cnt = (m_cnt == 7) ? 0 : m_cnt + 1;
                m_col = (m_col == 3) ? 0 : m_col + 1;
            end
        end else begin
            stall_r = 1'b0;
        end
    end

    initial begin
        reset = 1'b1;
        done = 1'b0;
        tbl_data = 8'd0;
        in_valid = 1'b0;
        in_pixel = 8'd0;
        out_ready = 1'b1;
        for (int k = 0; k < 256; k++) model_lut[k] = 8'd0;
        tick();
        tick();
        chk("reset_in_ready", in_ready, 32'd0);
        chk("reset_out_valid", out_valid, 32'd0);
        chk("reset_out_pixel", out_pixel, 32'd0);
        chk("reset_out_last", out_last, 32'd0);
        chk("reset_table_ready", table_ready, 32'd0);
        reset = 1'b0;
        tick();
        chk("idle_in_ready", in_ready, 32'd0);

        // Inverse table, three pixels back to back
        load_table(0, -1, -1);
        chk("run_in_ready", in_ready, 32'd1);
        send(8'h00);
        chk("latency_valid", out_valid, 32'd1);
        chk("latency_pixel", out_pixel, 32'hFF);
        send(8'h80);
        chk("stream_pixel", out_pixel, 32'h7F);
        send(8'hFF);
        chk("stream_pixel2", out_pixel, 32'h00);
        in_valid = 1'b0;
        drain();

        // Backpressure for three cycles mid-stream
        send(8'h01);
        send(8'h02);
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_pixel = 8'h03;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_ready", in_ready, 32'd0);
            tick();
        end
        out_ready = 1'b1;
        send(8'h03);
        send(8'h04);
        send(8'h05);
        in_valid = 1'b0;
        drain();

        // Reload with a concurrent handshake: that pixel uses the old table
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_pixel = 8'h42;
        #1;
        chk("reload_in_ready", in_ready, 32'd1);
        load_table(1, -1, -1);
        send(8'h42);
        chk("identity_pixel", out_pixel, 32'h42);

        // Frame end: nine more pixels, last lands on the eighth of the frame
        for (int i = 0; i < 9; i++) send(8'(i + 16));
        in_valid = 1'b0;
        drain();

        // done during LOAD is ignored
        load_table(0, 50, -1);
        send(8'h10);
        chk("after_ignored_done", out_pixel, 32'hEF);
        send(8'hF0);
        in_valid = 1'b0;
        drain();

        // Reset in the middle of a load with an output word pending
        out_ready = 1'b0;
        send(8'h10);
        in_valid = 1'b0;
        load_table(1, -1, 100);
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_pixel = 8'h33;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("post_reset_in_ready", in_ready, 32'd0);
            chk("post_reset_out_valid", out_valid, 32'd0);
            tick();
        end
        load_table(1, -1, -1);
        send(8'h33);
        chk("post_reset_pixel", out_pixel, 32'h33);
        in_valid = 1'b0;
        drain();

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
